multicycle_shift_unit: RTL and testbench

Iterative shift execution unit for the multicycle MIPS datapath. It accepts R-type shift instructions from the decode/execute stage through a start/busy/done handshake and shifts the operand by one bit position per clock. It implements SLL, SRL, SRA, SLLV, SRLV and SRAV. It also produces a combinational "is shift" flag for the control unit. The result is held stable for the register-file write-back stage.

---
 rtl/msu_pkg.sv | 27 ++
 rtl/shift_decode.sv | 36 +++
 rtl/multicycle_shift_unit.sv | 127 ++++++++++++
 tb/tb_multicycle_shift_unit.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/msu_pkg.sv
// Shared definitions for the multicycle shift unit.
// Contents: MIPS opcode/funct codes for the supported shifts, the FSM
// state encoding and the shift-kind encoding used by the decoder and top.
`timescale 1ns/1ps
package msu_pkg;

  localparam logic [5:0] OPC_RTYPE = 6'b000000;
  localparam logic [5:0] FUNC_SLL  = 6'b000000;
  localparam logic [5:0] FUNC_SRL  = 6'b000010;
  localparam logic [5:0] FUNC_SRA  = 6'b000011;
  localparam logic [5:0] FUNC_SLLV = 6'b000100;
  localparam logic [5:0] FUNC_SRLV = 6'b000110;
  localparam logic [5:0] FUNC_SRAV = 6'b000111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    KIND_LEFT   = 2'd0,
    KIND_LRIGHT = 2'd1,
    KIND_ARIGHT = 2'd2
  } kind_t;

endpackage

// File: rtl/shift_decode.sv
// Combinational decoder for the R-type shift instructions.
// Ports:
//   opcode_i  - instruction opcode field
//   func_i    - instruction funct field
//   valid_o   - {opcode, func} is one of SLL/SRL/SRA/SLLV/SRLV/SRAV
//   kind_o    - left, logical-right or arithmetic-right
//   var_sel_o - 1: amount comes from rs (variable form), 0: from shamt
`timescale 1ns/1ps
module shift_decode
  import msu_pkg::*;
(
  input  logic [5:0] opcode_i,
  input  logic [5:0] func_i,
  output logic       valid_o,
  output kind_t      kind_o,
  output logic       var_sel_o
);

  always_comb begin
    valid_o   = 1'b0;
    kind_o    = KIND_LEFT;
    var_sel_o = 1'b0;
    if (opcode_i == OPC_RTYPE) begin
      case (func_i)
        FUNC_SLL:  begin valid_o = 1'b1; kind_o = KIND_LEFT;   end
        FUNC_SRL:  begin valid_o = 1'b1; kind_o = KIND_LRIGHT; end
        FUNC_SRA:  begin valid_o = 1'b1; kind_o = KIND_ARIGHT; end
        FUNC_SLLV: begin valid_o = 1'b1; kind_o = KIND_LEFT;   var_sel_o = 1'b1; end
        FUNC_SRLV: begin valid_o = 1'b1; kind_o = KIND_LRIGHT; var_sel_o = 1'b1; end
        FUNC_SRAV: begin valid_o = 1'b1; kind_o = KIND_ARIGHT; var_sel_o = 1'b1; end
        default:   ;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_shift_unit.sv
// Iterative shift unit: shifts the rt operand one bit per clock.
// Ports:
//   clk, reset     - clock (rising edge), asynchronous active-low reset
//   msu_start_i    - request, only taken while idle with a supported op
//   msu_opcode_i   - opcode field;  msu_func_i - funct field
//   msu_shamt_i    - immediate amount;  msu_rs_i - low bits: variable amount
//   msu_rt_i       - operand to shift
//   msu_shift_o    - combinational: op is a supported shift
//   msu_busy_o     - unit occupied;  msu_done_o - one-cycle result-valid pulse
//   msu_result_o   - result, held until the next operation completes
`timescale 1ns/1ps
module multicycle_shift_unit
  import msu_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int SHAMT_WIDTH = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   msu_start_i,
  input  logic [5:0]             msu_opcode_i,
  input  logic [5:0]             msu_func_i,
  input  logic [SHAMT_WIDTH-1:0] msu_shamt_i,
  input  logic [DATA_WIDTH-1:0]  msu_rs_i,
  input  logic [DATA_WIDTH-1:0]  msu_rt_i,
  output logic                   msu_shift_o,
  output logic                   msu_busy_o,
  output logic                   msu_done_o,
  output logic [DATA_WIDTH-1:0]  msu_result_o
);

  localparam logic [SHAMT_WIDTH-1:0] CNT_ONE = SHAMT_WIDTH'(1);

  state_t                 state_q, state_d;
  logic [SHAMT_WIDTH-1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]  work_q, work_d;
  logic [DATA_WIDTH-1:0]  result_q, result_d;
  kind_t                  kind_q, kind_d;

  logic                   dec_valid;
  kind_t                  dec_kind;
  logic                   dec_var;
  logic [SHAMT_WIDTH-1:0] amount;
  logic [DATA_WIDTH-1:0]  work_shifted;
  logic                   accept;
  logic                   unused_rs_hi;

  shift_decode u_decode (
    .opcode_i  (msu_opcode_i),
    .func_i    (msu_func_i),
    .valid_o   (dec_valid),
    .kind_o    (dec_kind),
    .var_sel_o (dec_var)
  );

  // Only the low bits of rs carry the variable amount.
  assign unused_rs_hi = ^msu_rs_i[DATA_WIDTH-1:SHAMT_WIDTH];

  assign amount = dec_var ? msu_rs_i[SHAMT_WIDTH-1:0] : msu_shamt_i;
  assign accept = msu_start_i && dec_valid && (state_q == ST_IDLE);

  // One-bit step of the working register; arithmetic right replicates the MSB.
  always_comb begin
    case (kind_q)
      KIND_LEFT:   work_shifted = {work_q[DATA_WIDTH-2:0], 1'b0};
      KIND_LRIGHT: work_shifted = {1'b0, work_q[DATA_WIDTH-1:1]};
      default:     work_shifted = {work_q[DATA_WIDTH-1], work_q[DATA_WIDTH-1:1]};
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    work_d   = work_q;
    kind_d   = kind_q;
    result_d = result_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          work_d = msu_rt_i;
          cnt_d  = amount;
          kind_d = dec_kind;
          if (amount == '0) begin
            state_d  = ST_DONE;
            result_d = msu_rt_i;
          end else begin
            state_d = ST_SHIFT;
          end
        end
      end
      ST_SHIFT: begin
        work_d = work_shifted;
        cnt_d  = cnt_q - CNT_ONE;
        // The result register is loaded together with the last step so it
        // shows the new value exactly in the done cycle.
        if (cnt_q == CNT_ONE) begin
          state_d  = ST_DONE;
          result_d = work_shifted;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      work_q   <= '0;
      result_q <= '0;
      kind_q   <= KIND_LEFT;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      work_q   <= work_d;
      result_q <= result_d;
      kind_q   <= kind_d;
    end
  end

  assign msu_shift_o  = dec_valid;
  assign msu_busy_o   = (state_q != ST_IDLE);
  assign msu_done_o   = (state_q == ST_DONE);
  assign msu_result_o = result_q;

endmodule

// File: tb/tb_multicycle_shift_unit.sv
`timescale 1ns/1ps
module tb_multicycle_shift_unit;

  localparam int DW = 32;
  localparam int SW = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [5:0]    opcode, func;
  logic [SW-1:0] shamt;
  logic [DW-1:0] rs, rt;
  logic          shift_o, busy_o, done_o;
  logic [DW-1:0] result_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multicycle_shift_unit #(.DATA_WIDTH(DW), .SHAMT_WIDTH(SW)) dut (
    .clk          (clk),
    .reset        (reset),
    .msu_start_i  (start),
    .msu_opcode_i (opcode),
    .msu_func_i   (func),
    .msu_shamt_i  (shamt),
    .msu_rs_i     (rs),
    .msu_rt_i     (rt),
    .msu_shift_o  (shift_o),
    .msu_busy_o   (busy_o),
    .msu_done_o   (done_o),
    .msu_result_o (result_o)
  );

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic bit supported(input logic [5:0] opc, input logic [5:0] f);
    if (opc != 6'd0) return 1'b0;
    return (f == 6'd0) || (f == 6'd2) || (f == 6'd3) || (f == 6'd4) || (f == 6'd6) || (f == 6'd7);
  endfunction

  function automatic int model_amount(input logic [5:0] f, input logic [SW-1:0] sh, input logic [DW-1:0] rsv);
    if (f == 6'd4 || f == 6'd6 || f == 6'd7) return int'(rsv % 32);
    return int'(sh);
  endfunction

  function automatic logic [DW-1:0] model_shift(input logic [5:0] f, input logic [SW-1:0] sh,
                                                input logic [DW-1:0] rsv, input logic [DW-1:0] rtv);
    int n;
    n = model_amount(f, sh, rsv);
    case (f)
      6'd0, 6'd4: return rtv << n;
      6'd2, 6'd6: return rtv >> n;
      default:    return DW'($signed(rtv) >>> n);
    endcase
  endfunction

  // Timeline model: an accepted op occupies cycles accept+1 .. accept+N+1,
  // the last being the done cycle where the new result appears.
  int            cyc = 0;
  bit            m_active = 1'b0;
  int            m_done_cyc = 0;
  logic [DW-1:0] m_result = '0;
  logic [DW-1:0] m_new = '0;
  bit            idle_now, is_done;

  initial begin
    forever begin
      @(negedge clk);
      check("shift_o", shift_o, DW'(supported(opcode, func)));
      if (!reset) begin
        m_active = 1'b0;
        m_result = '0;
        check("busy_rst", busy_o, '0);
        check("done_rst", done_o, '0);
        check("result_rst", result_o, '0);
      end else begin
        idle_now = !m_active;
        is_done  = m_active && (cyc == m_done_cyc);
        check("busy", busy_o, DW'(m_active));
        check("done", done_o, DW'(is_done));
        check("result", result_o, is_done ? m_new : m_result);
        if (is_done) begin
          m_result = m_new;
          m_active = 1'b0;
        end
        if (idle_now && start && supported(opcode, func)) begin
          m_active   = 1'b1;
          m_new      = model_shift(func, shamt, rs, rt);
          m_done_cyc = cyc + 1 + model_amount(func, shamt, rs);
        end
      end
      cyc++;
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic drive_start(input logic [5:0] opc, input logic [5:0] f, input logic [SW-1:0] sh,
                             input logic [DW-1:0] rsv, input logic [DW-1:0] rtv);
    @(posedge clk); #1;
    opcode = opc; func = f; shamt = sh; rs = rsv; rt = rtv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_op(input string name, input logic [5:0] opc, input logic [5:0] f,
                        input logic [SW-1:0] sh, input logic [DW-1:0] rsv, input logic [DW-1:0] rtv,
                        input int exp_lat, input logic [DW-1:0] exp_res);
    int lat;
    bit seen;
    logic [DW-1:0] res;
    lat = 0; seen = 1'b0; res = '0;
    drive_start(opc, f, sh, rsv, rtv);
    for (int k = 1; k <= 40 && !seen; k++) begin
      @(negedge clk);
      if (done_o) begin
        seen = 1'b1;
        lat  = k;
        res  = result_o;
      end
    end
    check({name, " done_seen"}, DW'(seen), DW'(1));
    check({name, " latency"}, DW'(lat), DW'(exp_lat));
    check({name, " value"}, res, exp_res);
    $display("%s: rt=0x%08h done in cycle %0d result=0x%08h", name, rtv, lat, res);
  endtask

  initial begin
    start = 1'b0; opcode = '0; func = '0; shamt = '0; rs = '0; rt = '0;
    reset = 1'b1;
    #1 reset = 1'b0;
    #1;
    check("reset busy", busy_o, '0);
    check("reset done", done_o, '0);
    check("reset result", result_o, '0);
    repeat (2) @(negedge clk);
    @(posedge clk); #1 reset = 1'b1;

    run_op("SLL 1<<4",        6'd0, 6'd0, 5'd4,  32'h0,        32'h0000_0001, 5,  32'h0000_0010);
    run_op("SRA 8000_0000>>>31", 6'd0, 6'd3, 5'd31, 32'h0,     32'h8000_0000, 32, 32'hFFFF_FFFF);
    run_op("SRL 8000_0000>>31",  6'd0, 6'd2, 5'd31, 32'h0,     32'h8000_0000, 32, 32'h0000_0001);
    run_op("SRLV rs=25",      6'd0, 6'd6, 5'd9,  32'h0000_0025, 32'hF000_0000, 6, 32'h0780_0000);
    run_op("SLLV rs=FFFFFF21", 6'd0, 6'd4, 5'd7, 32'hFFFF_FF21, 32'h4000_0001, 2, 32'h8000_0002);
    run_op("SRAV rs=3",       6'd0, 6'd7, 5'd0,  32'h0000_0003, 32'h8000_0010, 4, 32'hF000_0002);
    run_op("SLL NOP",         6'd0, 6'd0, 5'd0,  32'h0,        32'h1234_5678, 1,  32'h1234_5678);
    check("NOP shift_o", DW'(shift_o), DW'(1));

    // Unsupported op (ADD): ignored entirely.
    @(posedge clk); #1;
    opcode = 6'd0; func = 6'b100000; rt = 32'hDEAD_BEEF; start = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("ADD shift_o", DW'(shift_o), '0);
      check("ADD busy", DW'(busy_o), '0);
      check("ADD result", result_o, 32'h1234_5678);
    end
    #1 start = 1'b0;
    $display("ADD start: ignored, result=0x%08h", result_o);

    // Start pulsed while busy: only the first op completes.
    begin
      int dones, lat;
      logic [DW-1:0] res;
      dones = 0; lat = 0; res = '0;
      drive_start(6'd0, 6'd2, 5'd8, 32'h0, 32'hFFFF_0000);
      for (int k = 1; k <= 20; k++) begin
        @(negedge clk);
        if (done_o) begin dones++; lat = k; res = result_o; end
        #1;
        if (k == 1) begin opcode = 6'd0; func = 6'd0; shamt = 5'd1; rt = 32'h0000_0001; start = 1'b1; end
        if (k == 4) start = 1'b0;
      end
      check("busy-start done count", DW'(dones), DW'(1));
      check("busy-start latency", DW'(lat), DW'(9));
      check("busy-start result", res, 32'h00FF_FF00);
      $display("SRL while-busy start: %0d done, cycle %0d result=0x%08h", dones, lat, res);
    end

    // Reset in cycle 3 of SLL by 10.
    drive_start(6'd0, 6'd0, 5'd10, 32'h0, 32'h0000_0001);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check("midreset busy", DW'(busy_o), '0);
    check("midreset done", DW'(done_o), '0);
    check("midreset result", result_o, '0);
    $display("Reset mid-shift: busy=%0b done=%0b result=0x%08h", busy_o, done_o, result_o);
    @(posedge clk); #1 reset = 1'b1;
    run_op("SRL 100>>8 after reset", 6'd0, 6'd2, 5'd8, 32'h0, 32'h0000_0100, 9, 32'h0000_0001);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
